// File: rtl/button_event.sv
// button_event: turns a clean, clk-synchronous button level into press,
// release, long-press and auto-repeat strobes. It also reports a pressed
// level and counts the repeats issued during the current press.
module button_event #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_WIDTH     = 26,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data,
  input  logic       enable,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [7:0] repeat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HELD  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  // Terminal counts. Each value is one less than its period, so a period
  // of 2^CNT_WIDTH still fits in the timer.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_LAST : REPEAT_LAST;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [7:0]           r_rep_cnt;
  logic [7:0]           w_rep_cnt_next;
  logic                 r_press;
  logic                 r_release;
  logic                 r_long;
  logic                 r_repeat;
  logic                 w_press_next;
  logic                 w_release_next;
  logic                 w_long_next;
  logic                 w_repeat_next;
  logic                 w_act;

  // Normalise the button polarity: w_act = 1 means pressed.
  assign w_act = data ^ ACTIVE_LOW;

  // State register, timer, repeat counter and registered strobes.
  // Reset enters LOCK, so a button held through reset stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOCK;
      r_cnt     <= '0;
      r_rep_cnt <= 8'd0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rep_cnt <= w_rep_cnt_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_long    <= w_long_next;
      r_repeat  <= w_repeat_next;
    end
  end

  // Next-state logic. Disable wins over everything, including a release.
  // In PRESS and HELD a release on the threshold edge wins over that threshold.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rep_cnt_next = r_rep_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_long_next    = 1'b0;
    w_repeat_next  = 1'b0;
    if (!enable) begin
      w_state_next = S_LOCK;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_act) begin
            w_state_next   = S_PRESS;
            w_press_next   = 1'b1;
            w_cnt_next     = '0;
            w_rep_cnt_next = 8'd0;
          end
        end
        S_PRESS: begin
          if (!w_act) begin
            w_state_next   = S_IDLE;
            w_release_next = 1'b1;
          end else if (r_cnt == HOLD_LAST) begin
            w_state_next = S_HELD;
            w_long_next  = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!w_act) begin
            w_state_next   = S_IDLE;
            w_release_next = 1'b1;
          end else if (r_cnt == REPEAT_LAST) begin
            w_repeat_next = 1'b1;
            w_cnt_next    = '0;
            if (r_rep_cnt != 8'hFF) begin
              w_rep_cnt_next = r_rep_cnt + 8'd1;
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_LOCK: begin
          // Leave only once the button is seen released, so a held button
          // does not produce a press when the block is re-enabled.
          if (!w_act) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_LOCK;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode: pressed follows the state, and strobes come from their registers.
  always_comb begin
    pressed       = (r_state == S_PRESS) || (r_state == S_HELD);
    press_pulse   = r_press;
    release_pulse = r_release;
    long_pulse    = r_long;
    repeat_pulse  = r_repeat;
    repeat_cnt    = r_rep_cnt;
  end

  // The timer resets on every threshold, so it never passes the larger terminal count.
  assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CNT_MAX);

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed scoreboard bench for button_event. Two DUTs run
// side by side: an active-low one and an active-high one driven with the
// inverted level. Both must show the same strobe timing.
module tb_button_event;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data;
  logic       data_n;
  logic       enable;

  logic       pressed0, pp0, rl0, lp0, rp0;
  logic [7:0] rc0;
  logic       pressed1, pp1, rl1, lp1, rp1;
  logic [7:0] rc1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int kind;
    int rcnt;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  assign data_n = ~data;

  button_event #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .CNT_WIDTH    (8),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .enable       (enable),
    .pressed      (pressed0),
    .press_pulse  (pp0),
    .release_pulse(rl0),
    .long_pulse   (lp0),
    .repeat_pulse (rp0),
    .repeat_cnt   (rc0)
  );

  button_event #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .CNT_WIDTH    (8),
    .ACTIVE_LOW   (1'b0)
  ) dut_hi (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data_n),
    .enable       (enable),
    .pressed      (pressed1),
    .press_pulse  (pp1),
    .release_pulse(rl1),
    .long_pulse   (lp1),
    .repeat_pulse (rp1),
    .repeat_cnt   (rc1)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0:       return "press";
      1:       return "release";
      2:       return "long";
      3:       return "repeat";
      default: return "none";
    endcase
  endfunction

  task automatic expect_ev(input int c, input int k, input int r);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.rcnt = r;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d, required %0d", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0d", name, cyc, act);
    end
  endtask

  // Match every strobe against the head of that DUT's expectation queue.
  task automatic mon(input int id, input logic [3:0] s, input logic [7:0] rc);
    for (int k = 0; k < 4; k++) begin
      ev_t e;
      bit  have;
      have = 1'b0;
      if (s[k]) begin
        if (id == 0 && q0.size() > 0) begin
          e = q0.pop_front();
          have = 1'b1;
        end else if (id == 1 && q1.size() > 0) begin
          e = q1.pop_front();
          have = 1'b1;
        end
        vectors++;
        if (!have) begin
          errors++;
          $display("FAIL strobe dut%0d cyc=%0d: got %s, required no strobe", id, cyc, kname(k));
        end else if (e.kind != k || e.cyc != cyc || (e.rcnt >= 0 && e.rcnt != int'(rc))) begin
          errors++;
          $display("FAIL strobe dut%0d: got %s at cyc %0d rcnt=%0d, required %s at cyc %0d rcnt=%0d",
                   id, kname(k), cyc, rc, kname(e.kind), e.cyc, e.rcnt);
        end else begin
          $display("ok   strobe dut%0d %s cyc=%0d rcnt=%0d", id, kname(k), cyc, rc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, {rp0, lp0, rl0, pp0}, rc0);
    mon(1, {rp1, lp1, rl1, pp1}, rc1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pressed"}, pressed0, 0);
    chk({name, "_strobes"}, {pp0, rl0, lp0, rp0}, 0);
    chk({name, "_rcnt"}, rc0, 0);
    chk({name, "_hi_pressed"}, pressed1, 0);
    chk({name, "_hi_rcnt"}, rc1, 0);
  endtask

  // Hold the button for n sampled edges, then release it. Expectations come
  // from HOLD=10 and REPEAT=4: long at +10, repeats at +10+4k, release at +n.
  task automatic press_for(input int n);
    int t0;
    int nrep;
    tick();
    data = 1'b0;
    t0 = cyc;
    nrep = 0;
    expect_ev(t0 + 1, 0, -1);
    if (n > 10) begin
      expect_ev(t0 + 1 + 10, 2, -1);
      for (int k = 1; 10 + 4 * k < n; k++) begin
        nrep = k;
        expect_ev(t0 + 1 + 10 + 4 * k, 3, (k > 255) ? 255 : k);
      end
    end
    if (nrep > 255) nrep = 255;
    expect_ev(t0 + 1 + n, 1, nrep);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (n <= 30 || i == n) chk("pressed_hi", pressed0, 1);
    end
    data = 1'b1;
    tick();
    chk("pressed_lo", pressed0, 0);
    idle(3);
    chk("rcnt_hold", rc0, nrep);
  endtask

  initial begin
    int t0;
    rst_n  = 1'b0;
    data   = 1'b1;
    enable = 1'b1;
    #1;
    chk_all_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // short, long, tie, and one-past-tie presses
    press_for(5);
    press_for(25);
    press_for(10);
    press_for(11);

    // lockout while held: disable at +3, re-enable at +8, keep holding
    tick();
    data = 1'b0;
    t0 = cyc;
    expect_ev(t0 + 1, 0, -1);
    idle(3);
    enable = 1'b0;
    tick();
    chk("lock_pressed", pressed0, 0);
    idle(4);
    enable = 1'b1;
    idle(15);
    chk("lock_held_pressed", pressed0, 0);
    data = 1'b1;
    idle(2);
    press_for(5);

    // a release on a disable edge must not give release_pulse
    tick();
    data = 1'b0;
    t0 = cyc;
    expect_ev(t0 + 1, 0, -1);
    idle(2);
    enable = 1'b0;
    data = 1'b1;
    idle(3);
    chk("dis_rel_pressed", pressed0, 0);
    enable = 1'b1;
    idle(2);
    press_for(5);

    // button held through reset: silent until released and pressed again
    tick();
    rst_n = 1'b0;
    data = 1'b0;
    #1;
    chk_all_zero("rst_held");
    idle(3);
    rst_n = 1'b1;
    idle(15);
    chk("rst_held_after", pressed0, 0);
    data = 1'b1;
    idle(2);
    press_for(5);

    // asynchronous reset in the middle of HELD, after one repeat
    tick();
    data = 1'b0;
    t0 = cyc;
    expect_ev(t0 + 1, 0, -1);
    expect_ev(t0 + 11, 2, -1);
    expect_ev(t0 + 15, 3, 1);
    idle(16);
    chk("held_pressed", pressed0, 1);
    chk("held_rcnt", rc0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    data = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // repeat_cnt saturation at 255
    press_for(1040);

    idle(3);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
